// File: rtl/piece_arb_pkg.sv
// Shared constants and lock-state encoding for the piece_arb round-robin merge arbiter.
package piece_arb_pkg;

    localparam int DATA_W      = 64;
    localparam int BE_W        = 8;
    localparam int LAST_BE_BIT = 7;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/piece_arb_rr.sv
// Combinational round-robin picker: first requester after rr_ptr_i, wrapping modulo NUM_SRC.
module piece_arb_rr #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   rr_ptr_i,
    output logic [SRC_W-1:0]   sel_o,
    output logic               any_o
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        sel_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rr_ptr_i) + k) % NUM_SRC;
            if (!any_o && req_i[idx]) begin
                sel_o = SRC_W'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piece_arb.sv
// Round-robin piece arbiter with word lock and one-entry show-ahead output register.
// Optional locked-idle watchdog enabled by PIECE_ARB_WDOG_EN.
module piece_arb
    import piece_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
`ifdef PIECE_ARB_WDOG_EN
    ,
    parameter int WDOG_CYC = 1024
`endif
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic [DATA_W*NUM_SRC-1:0] src_rd_data,
    input  logic [BE_W*NUM_SRC-1:0]   src_rd_be,
    input  logic [NUM_SRC-1:0]        src_ne,
    output logic [NUM_SRC-1:0]        src_re,
    output logic [DATA_W-1:0]         mrg_rd_data,
    output logic [BE_W-1:0]           mrg_rd_be,
    output logic                      mrg_ne,
    input  logic                      mrg_re,
    output logic [SRC_W-1:0]          mrg_src
`ifdef PIECE_ARB_WDOG_EN
    ,
    output logic                      wdog_err
`endif
);

    lock_state_e        state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic               ne_q, ne_d;
    logic [SRC_W-1:0]   src_q, src_d;

    logic [SRC_W-1:0]   rr_sel;
    logic               rr_any;
    logic [SRC_W-1:0]   sel;
    logic               cand;
    logic               load;
    logic [DATA_W-1:0]  piece_data;
    logic [BE_W-1:0]    piece_be;

    piece_arb_rr #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr (
        .req_i    (src_ne),
        .rr_ptr_i (rr_ptr_q),
        .sel_o    (rr_sel),
        .any_o    (rr_any)
    );

    // While locked only the granted source may feed the partial word, even if it is empty.
    assign sel        = (state_q == LOCKED) ? grant_q : rr_sel;
    assign cand       = (state_q == LOCKED) ? src_ne[grant_q] : rr_any;
    assign load       = (!ne_q || mrg_re) && cand;
    assign piece_data = src_rd_data[DATA_W*sel +: DATA_W];
    assign piece_be   = src_rd_be[BE_W*sel +: BE_W];

    always_comb begin
        src_re = '0;
        if (load) begin
            src_re[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        be_d     = be_q;
        ne_d     = ne_q;
        src_d    = src_q;
        if (load) begin
            data_d = piece_data;
            be_d   = piece_be;
            src_d  = sel;
            ne_d   = 1'b1;
            if (piece_be[LAST_BE_BIT]) begin
                state_d  = UNLOCKED;
                rr_ptr_d = sel;
            end else begin
                state_d = LOCKED;
                grant_d = sel;
            end
        end else if (mrg_re) begin
            ne_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= UNLOCKED;
            grant_q  <= '0;
            rr_ptr_q <= SRC_W'(NUM_SRC - 1);
            data_q   <= '0;
            be_q     <= '0;
            ne_q     <= 1'b0;
            src_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            ne_q     <= ne_d;
            src_q    <= src_d;
        end
    end

    assign mrg_rd_data = data_q;
    assign mrg_rd_be   = be_q;
    assign mrg_ne      = ne_q;
    assign mrg_src     = src_q;

`ifdef PIECE_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;
    logic              locked_idle;

    assign locked_idle = (state_q == LOCKED) && !src_ne[grant_q];

    // Counter saturates at the limit so the flag cannot be lost to wrap-around.
    always_comb begin
        wdog_cnt_d = '0;
        if (locked_idle) begin
            wdog_cnt_d = (wdog_cnt_q == WDOG_W'(WDOG_CYC)) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
        end
        wdog_err_d = wdog_err_q || (wdog_cnt_d == WDOG_W'(WDOG_CYC));
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`endif

endmodule

// File: tb/tb_piece_arb.sv
// Directed self-checking bench for piece_arb (NUM_SRC=4); watchdog steps run when PIECE_ARB_WDOG_EN is defined.
module tb_piece_arb;

    logic         clk;
    logic         reset_l;
    logic [255:0] src_rd_data;
    logic [31:0]  src_rd_be;
    logic [3:0]   src_ne;
    logic [3:0]   src_re;
    logic [63:0]  mrg_rd_data;
    logic [7:0]   mrg_rd_be;
    logic         mrg_ne;
    logic         mrg_re;
    logic [1:0]   mrg_src;
`ifdef PIECE_ARB_WDOG_EN
    logic         wdog_err;
`endif

    int total = 0;
    int bad   = 0;

    piece_arb #(
        .NUM_SRC (4),
        .SRC_W   (2)
`ifdef PIECE_ARB_WDOG_EN
        ,
        .WDOG_CYC (8)
`endif
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .src_rd_data (src_rd_data),
        .src_rd_be   (src_rd_be),
        .src_ne      (src_ne),
        .src_re      (src_re),
        .mrg_rd_data (mrg_rd_data),
        .mrg_rd_be   (mrg_rd_be),
        .mrg_ne      (mrg_ne),
        .mrg_re      (mrg_re),
        .mrg_src     (mrg_src)
`ifdef PIECE_ARB_WDOG_EN
        ,
        .wdog_err    (wdog_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic ne, input logic [7:0] be, input logic [63:0] data);
        src_ne[i]              = ne;
        src_rd_be[8*i +: 8]    = be;
        src_rd_data[64*i +: 64] = data;
    endtask

    // Inputs are driven just after posedge; outputs are sampled on the following negedge.
    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        src_ne  = '0;
        to_sample();
        to_drive();
        reset_l = 1'b1;
    endtask

    initial begin
        reset_l     = 1'b0;
        src_rd_data = '0;
        src_rd_be   = '0;
        src_ne      = '0;
        mrg_re      = 1'b0;

        // Reset values
        to_sample();
        check("rst_ne",   64'(mrg_ne), 64'h0);
        check("rst_data", mrg_rd_data, 64'h0);
        check("rst_be",   64'(mrg_rd_be), 64'h0);
        check("rst_src",  64'(mrg_src), 64'h0);
        check("rst_re",   64'(src_re), 64'h0);
`ifdef PIECE_ARB_WDOG_EN
        check("rst_wdog", 64'(wdog_err), 64'h0);
`endif
        to_drive();
        reset_l = 1'b1;
        mrg_re  = 1'b1;

        // 1: single source, two-piece word
        set_src(0, 1'b1, 8'h0F, 64'h0000_0000_0000_100F);
        to_sample();
        check("t1_re0", 64'(src_re), 64'h1);
        to_drive();
        set_src(0, 1'b1, 8'hF0, 64'h0000_0000_0000_10F0);
        to_sample();
        check("t1_re1", 64'(src_re), 64'h1);
        check("t1_be0", 64'(mrg_rd_be), 64'h0F);
        check("t1_src0", 64'(mrg_src), 64'h0);
        check("t1_ne0", 64'(mrg_ne), 64'h1);
        to_drive();
        src_ne = '0;
        to_sample();
        check("t1_be1", 64'(mrg_rd_be), 64'hF0);
        check("t1_src1", 64'(mrg_src), 64'h0);
        check("t1_re_idle", 64'(src_re), 64'h0);
        to_drive();
        set_src(1, 1'b1, 8'hFF, 64'h0000_0000_0000_1001);
        to_sample();
        check("t1_ne_drain", 64'(mrg_ne), 64'h0);
        check("t1_be_hold", 64'(mrg_rd_be), 64'hF0);
        check("t1_unlocked", 64'(src_re), 64'h2);
        to_drive();
        do_reset();

        // 2: round robin across all four sources, two rounds
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 8'hFF, 64'h2000 + 64'(i));
        for (int k = 0; k < 8; k++) begin
            to_sample();
            check("t2_re", 64'(src_re), 64'(1 << (k % 4)));
            if (k > 0) begin
                check("t2_src", 64'(mrg_src), 64'((k - 1) % 4));
                check("t2_data", mrg_rd_data, 64'h2000 + 64'((k - 1) % 4));
            end
            to_drive();
        end
        src_ne = '0;
        to_sample();
        check("t2_src_last", 64'(mrg_src), 64'h3);
        check("t2_ne_last", 64'(mrg_ne), 64'h1);
        to_drive();

        // 3: lock holds src1 across an empty gap while src2 waits
        set_src(1, 1'b1, 8'h03, 64'h3001);
        set_src(2, 1'b1, 8'hFF, 64'h3002);
        to_sample();
        check("t3_re_first", 64'(src_re), 64'h2);
        to_drive();
        src_ne[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            to_sample();
            check("t3_re_hold", 64'(src_re), 64'h0);
            if (k == 0) begin
                check("t3_be03", 64'(mrg_rd_be), 64'h03);
                check("t3_src1", 64'(mrg_src), 64'h1);
            end
            to_drive();
        end
        set_src(1, 1'b1, 8'h80, 64'h3011);
        to_sample();
        check("t3_re_last", 64'(src_re), 64'h2);
        to_drive();
        src_ne[1] = 1'b0;
        to_sample();
        check("t3_be80", 64'(mrg_rd_be), 64'h80);
        check("t3_re_src2", 64'(src_re), 64'h4);
        to_drive();
        src_ne = '0;
        to_sample();
        check("t3_src2", 64'(mrg_src), 64'h2);
        check("t3_data2", mrg_rd_data, 64'h3002);
        to_drive();

        // 4: back-pressure, then same-cycle consume and load
        set_src(3, 1'b1, 8'hFF, 64'h4003);
        set_src(0, 1'b1, 8'hFF, 64'h4000);
        to_sample();
        check("t4_re3", 64'(src_re), 64'h8);
        to_drive();
        mrg_re = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_sample();
            check("t4_re_stall", 64'(src_re), 64'h0);
            check("t4_data_stable", mrg_rd_data, 64'h4003);
            check("t4_ne_stall", 64'(mrg_ne), 64'h1);
            to_drive();
        end
        mrg_re = 1'b1;
        to_sample();
        check("t4_re0", 64'(src_re), 64'h1);
        to_drive();
        src_ne = '0;
        to_sample();
        check("t4_ne_nobubble", 64'(mrg_ne), 64'h1);
        check("t4_data0", mrg_rd_data, 64'h4000);
        check("t4_src0", 64'(mrg_src), 64'h0);
        to_drive();

        // 5: reset while locked on src3
        set_src(3, 1'b1, 8'h01, 64'h5003);
        to_sample();
        check("t5_re3", 64'(src_re), 64'h8);
        to_drive();
        mrg_re = 1'b0;
        src_ne[3] = 1'b0;
        set_src(0, 1'b1, 8'hFF, 64'h5000);
        to_sample();
        check("t5_locked", 64'(src_re), 64'h0);
        check("t5_src3", 64'(mrg_src), 64'h3);
        to_drive();
        reset_l = 1'b0;
        src_ne  = '0;
        mrg_re  = 1'b1;
        #1;
        check("t5_rst_ne", 64'(mrg_ne), 64'h0);
        check("t5_rst_data", mrg_rd_data, 64'h0);
        check("t5_rst_be", 64'(mrg_rd_be), 64'h0);
        check("t5_rst_src", 64'(mrg_src), 64'h0);
        to_drive();
        reset_l = 1'b1;
        set_src(0, 1'b1, 8'hFF, 64'h5000);
        set_src(3, 1'b1, 8'hFF, 64'h5013);
        to_sample();
        check("t5_re_src0", 64'(src_re), 64'h1);
        to_drive();
        src_ne = '0;
        to_sample();
        check("t5_out_src0", 64'(mrg_src), 64'h0);
        check("t5_out_data", mrg_rd_data, 64'h5000);
        to_drive();

`ifdef PIECE_ARB_WDOG_EN
        // 6: watchdog on a locked, idle src2
        set_src(2, 1'b1, 8'h00, 64'h6002);
        to_sample();
        check("t6_re2", 64'(src_re), 64'h4);
        to_drive();
        src_ne = '0;
        for (int k = 1; k <= 8; k++) begin
            to_sample();
            check("t6_wdog_low", 64'(wdog_err), 64'h0);
            check("t6_re_idle", 64'(src_re), 64'h0);
            if (k == 1) check("t6_be00", 64'(mrg_rd_be), 64'h00);
            to_drive();
        end
        set_src(2, 1'b1, 8'h80, 64'h6012);
        to_sample();
        check("t6_wdog_set", 64'(wdog_err), 64'h1);
        check("t6_re_resume", 64'(src_re), 64'h4);
        to_drive();
        src_ne = '0;
        to_sample();
        check("t6_wdog_sticky", 64'(wdog_err), 64'h1);
        check("t6_be80", 64'(mrg_rd_be), 64'h80);
        to_drive();
        to_sample();
        check("t6_wdog_sticky2", 64'(wdog_err), 64'h1);
        to_drive();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
